// File: rtl/led_mmio.sv
// led_mmio: memory-mapped LED bank responder with an optional per-bit blink engine.
// Build option: define LED_BLINK_EN to include BLINK_MASK, PRESCALE, STATUS and the
// blink counter. Without it only LED_OUT/LED_SET/LED_CLR are mapped.
module led_mmio #(
  parameter int unsigned LED_W      = 8,
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned PRESCALE_W = 24,
  parameter logic [PRESCALE_W-1:0] DEFAULT_PRESCALE = PRESCALE_W'(4_999_999)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [LED_W-1:0]  led
);

  localparam logic [ADDR_W-1:0] OFF_OUT  = ADDR_W'(8'h00);
  localparam logic [ADDR_W-1:0] OFF_SET  = ADDR_W'(8'h04);
  localparam logic [ADDR_W-1:0] OFF_CLR  = ADDR_W'(8'h08);
`ifdef LED_BLINK_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(8'h0C);
  localparam logic [ADDR_W-1:0] OFF_PRE  = ADDR_W'(8'h10);
  localparam logic [ADDR_W-1:0] OFF_STAT = ADDR_W'(8'h14);
`endif

  typedef enum logic {IDLE, RESP} state_t;

  state_t           state;
  logic [LED_W-1:0] led_out;
  logic             sel_out, sel_set, sel_clr, hit, dec_err;
  logic [31:0]      rd_val;
  logic             accept, wr_en;
  logic             unused_wdata;

`ifdef LED_BLINK_EN
  logic                  sel_mask, sel_pre, sel_stat;
  logic [LED_W-1:0]      blink_mask;
  logic [PRESCALE_W-1:0] prescale;
  logic [PRESCALE_W-1:0] cnt;
  logic                  phase;
`else
  logic                  unused_cfg;
  assign unused_cfg = ^DEFAULT_PRESCALE;
`endif

  // upper write-data bits beyond the register widths are intentionally dropped
  assign unused_wdata = ^req_wdata;

  // req_ready is only high in IDLE, so it doubles as the accept qualifier
  assign accept = req_valid && req_ready;
  assign wr_en  = accept && req_we && !dec_err;

  // address decode and read mux; misaligned offsets match no entry and fall into error
  always_comb begin
    sel_out = 1'b0;
    sel_set = 1'b0;
    sel_clr = 1'b0;
    rd_val  = '0;
`ifdef LED_BLINK_EN
    sel_mask = 1'b0;
    sel_pre  = 1'b0;
    sel_stat = 1'b0;
`endif
    case (req_addr)
      OFF_OUT: begin
        sel_out = 1'b1;
        rd_val  = 32'(led_out);
      end
      OFF_SET: sel_set = 1'b1;
      OFF_CLR: sel_clr = 1'b1;
`ifdef LED_BLINK_EN
      OFF_MASK: begin
        sel_mask = 1'b1;
        rd_val   = 32'(blink_mask);
      end
      OFF_PRE: begin
        sel_pre = 1'b1;
        rd_val  = 32'(prescale);
      end
      OFF_STAT: begin
        sel_stat = 1'b1;
        rd_val   = 32'(phase);
      end
`endif
      default: ;
    endcase
    hit = sel_out | sel_set | sel_clr;
`ifdef LED_BLINK_EN
    hit = hit | sel_mask | sel_pre | sel_stat;
`endif
    dec_err = !hit;
`ifdef LED_BLINK_EN
    if (req_we && sel_stat) dec_err = 1'b1;
`endif
  end

  // request/response handshake FSM; response fields held until consumed
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            state     <= RESP;
            req_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (req_we || dec_err) ? 32'd0 : rd_val;
            rsp_err   <= dec_err;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // static LED pattern with set/clear aliases
  always_ff @(posedge clk) begin
    if (!rst) begin
      led_out <= '0;
    end else if (wr_en) begin
      if (sel_out) led_out <= req_wdata[LED_W-1:0];
      if (sel_set) led_out <= led_out | req_wdata[LED_W-1:0];
      if (sel_clr) led_out <= led_out & ~req_wdata[LED_W-1:0];
    end
  end

`ifdef LED_BLINK_EN
  // blink configuration registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      blink_mask <= '0;
      prescale   <= DEFAULT_PRESCALE;
    end else if (wr_en) begin
      if (sel_mask) blink_mask <= req_wdata[LED_W-1:0];
      if (sel_pre)  prescale   <= req_wdata[PRESCALE_W-1:0];
    end
  end

  // half-period counter; a PRESCALE write restarts it and suppresses a coincident toggle
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (wr_en && sel_pre) begin
      cnt <= '0;
    end else if (cnt == prescale) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + PRESCALE_W'(1);
    end
  end

  // blinking bits are forced off during the active phase
  always_ff @(posedge clk) begin
    if (!rst) led <= '0;
    else      led <= led_out & ~(blink_mask & {LED_W{phase}});
  end
`else
  // LED pins follow the static pattern one cycle later
  always_ff @(posedge clk) begin
    if (!rst) led <= '0;
    else      led <= led_out;
  end
`endif

endmodule

// File: doc/led_mmio.md
# led_mmio

Memory-mapped LED output peripheral: the bus responder that drives the board's 8-bit `led` bank from CPU store and load requests. Sits between the datapath's data-memory request port and the `led` pin of `top`, and decodes a small register window. It replaces direct wiring of a register to the pins. It adds a per-bit hardware blink engine so firmware can show progress without polling.

## Interface
- `LED_W`, 8, width of the LED bank (1..32)
- `ADDR_W`, 5, byte-address width of the register window
- `PRESCALE_W`, 24, width of the blink prescaler
- `DEFAULT_PRESCALE`, 24'd4_999_999, reset value of PRESCALE
- `clk`  in  1  sole clock, all state on rising edge
- `rst`  in  1  synchronous, active-low reset (sampled on `clk`; 0 = reset)
- `req_valid`  in  1  request present
- `req_ready`  out  1  responder can accept
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  ADDR_W  byte address
- `req_wdata`  in  32  write data
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  initiator consumes response
- `rsp_rdata`  out  32  read data; 0 for writes and errors
- `rsp_err`  out  1  misaligned, unmapped, or illegal access
- `led`  out  LED_W  registered LED drive

## Operation
- Register map (byte offsets; `addr[1:0]` must be 0b00, otherwise error):
  - 0x00 LED_OUT (RW): static pattern.
  - 0x04 LED_SET (W): `LED_OUT |= wdata`. Reads return 0 with no error.
  - 0x08 LED_CLR (W): `LED_OUT &= ~wdata`. Reads return 0 with no error.
  - 0x0C BLINK_MASK (RW): per-bit blink enable.
  - 0x10 PRESCALE (RW): blink half-period minus 1.
  - 0x14 STATUS (RO): bit0 = blink phase. A write sets `rsp_err`.
  - Any other offset: error.
- Write data is truncated to `LED_W` or `PRESCALE_W` bits. Reads are zero-extended to 32 bits.
- An error response changes no state.
- FSM:
  - IDLE: `req_ready`=1. On `req_valid`, perform the access at that edge and go to RESP.
  - RESP: `rsp_valid`=1 and `req_ready`=0. Hold `rsp_rdata`/`rsp_err` stable until `rsp_valid && rsp_ready`, then go to IDLE.
- Blink engine:
  - `cnt` increments every cycle.
  - When `cnt == PRESCALE`: `cnt` returns to 0 and `phase` toggles.
  - PRESCALE = 0 gives a phase toggle every cycle.
- Output: `led <= LED_OUT & ~(BLINK_MASK & {LED_W{phase}})`, registered.

## Timing
- Reset values:
  - `req_ready`=0 while `rst`=0. It is 1 on the first cycle after release.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `led`=0.
  - LED_OUT=0, BLINK_MASK=0, PRESCALE=DEFAULT_PRESCALE, `cnt`=0, `phase`=0.
- Request accepted at edge N: `rsp_valid` goes high after N. The register is updated at N. `led` reflects the update after edge N+1.
- Minimum spacing between accepted requests is 2 cycles (rsp_ready tied high).
- Read data is the register value before edge N.
- Write to PRESCALE at edge N: `cnt` is cleared to 0 at N. If `cnt` would have wrapped at N, the write wins and `phase` does not toggle.
- Writes to LED_OUT, LED_SET, LED_CLR and BLINK_MASK never affect `cnt` or `phase`.
- `rst`=0 during RESP: the response is dropped at that edge. No `rsp_valid` is seen after reset.
- `req_valid` held high during RESP is ignored. It is accepted on the first IDLE cycle.

## Configuration
- `LED_BLINK_EN` defined: blink engine, BLINK_MASK, PRESCALE and STATUS are present as described.
- `LED_BLINK_EN` undefined:
  - No counter or phase logic.
  - Offsets 0x0C/0x10/0x14 are unmapped and return `rsp_err`=1.
  - `led <= LED_OUT`, with the same one-cycle latency.

## Test plan
- Reset: hold `rst`=0 for 2 cycles -> `led`=0x00, `rsp_valid`=0. After release, read 0x10 -> `rsp_rdata`=4_999_999.
- Write 0x00 = 0xA5, then SET 0x0F, then CLR 0x81:
  - `led` = 0xA5, then 0xAF, then 0x2E, each one cycle after acceptance.
  - Reads of 0x04 return 0.
- Blink (LED_BLINK_EN), first part: PRESCALE=3, LED_OUT=0xFF, BLINK_MASK=0x0F -> `led` alternates 0xFF/0xF0 every 4 cycles. STATUS bit0 tracks `phase`.
- Blink (LED_BLINK_EN), second part: write PRESCALE=3 exactly on a wrap cycle -> no toggle, next toggle 4 cycles later.
- Errors:
  - Read 0x02 -> `rsp_err`=1, `rsp_rdata`=0, state unchanged.
  - Write 0x14 -> `rsp_err`=1.
  - Read 0x18 -> `rsp_err`=1.
  - Without LED_BLINK_EN, read 0x0C -> `rsp_err`=1.
- Backpressure: hold `rsp_ready`=0 for 5 cycles with `req_valid`=1 -> `req_ready`=0 throughout and `rsp_rdata` stable. The second request is accepted on the cycle after the handshake.
- Reset mid-response: drive `rst`=0 while `rsp_valid`=1 -> `rsp_valid`=0 at the next edge and `led`=0.
